// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI4 address generator for FIXED, INCR and WRAP bursts.
// It checks each request when it is accepted, then steps one address per acknowledged beat.
module axi_burst_addr_gen #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int LEN_WIDTH      = 8,
  parameter int MAX_SIZE       = 3
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_start,
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  input  logic [LEN_WIDTH-1:0]      i_len,
  input  logic [2:0]                i_size,
  input  logic [1:0]                i_burst,
  input  logic                      i_beat_ack,
  input  logic                      i_abort,
  output logic [AXI_ADDR_WIDTH-1:0] o_addr,
  output logic                      o_beat_valid,
  output logic                      o_last,
  output logic [LEN_WIDTH-1:0]      o_beat_idx,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int                    AW         = AXI_ADDR_WIDTH;
  localparam logic [AW-1:0]         ONE        = AW'(1);
  localparam logic [2:0]            MAX_SIZE_L = 3'(MAX_SIZE);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE    = LEN_WIDTH'(1);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  beat_idx_q, beat_idx_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [2:0]            size_q, size_d;
  burst_e                burst_q, burst_d;
  logic [AW-1:0]         wrap_lower_q, wrap_lower_d;
  logic [AW-1:0]         wrap_upper_q, wrap_upper_d;
  logic                  err_q, err_d;

  // Request legality, evaluated on the raw request inputs.
  logic [AW-1:0] req_beat_bytes;
  logic [AW-1:0] req_size_mask;
  logic [AW-1:0] req_aligned;
  logic [AW-1:0] req_total_bytes;
  logic [AW-1:0] req_last_byte;
  logic [AW-1:0] req_wrap_lower;
  logic [AW-1:0] req_wrap_upper;
  logic          size_bad;
  logic          burst_bad;
  logic          wrap_len_bad;
  logic          wrap_align_bad;
  logic          incr_4k_bad;
  logic          req_is_wrap;
  logic          req_is_incr;
  logic          req_illegal;

  always_comb begin
    req_beat_bytes  = ONE << i_size;
    req_size_mask   = req_beat_bytes - ONE;
    req_aligned     = i_addr & ~req_size_mask;
    req_total_bytes = (AW'(i_len) + ONE) << i_size;
    req_last_byte   = req_aligned + req_total_bytes - ONE;
    req_wrap_lower  = i_addr & ~(req_total_bytes - ONE);
    req_wrap_upper  = req_wrap_lower + req_total_bytes;

    req_is_wrap    = (i_burst == BURST_WRAP);
    req_is_incr    = (i_burst == BURST_INCR);
    size_bad       = (i_size > MAX_SIZE_L);
    burst_bad      = (i_burst == BURST_RSVD);
    wrap_len_bad   = !((i_len == LEN_WIDTH'(1)) || (i_len == LEN_WIDTH'(3)) ||
                       (i_len == LEN_WIDTH'(7)) || (i_len == LEN_WIDTH'(15)));
    wrap_align_bad = ((i_addr & req_size_mask) != '0);
    // Only the page number matters; the byte offset inside the 4 KB page is ignored.
    incr_4k_bad    = (req_aligned[AW-1:12] != req_last_byte[AW-1:12]);

    req_illegal = size_bad || burst_bad ||
                  (req_is_wrap && (wrap_len_bad || wrap_align_bad)) ||
                  (req_is_incr && incr_4k_bad);
  end

  // Next-beat address, computed from the latched burst.
  logic [AW-1:0] cur_beat_bytes;
  logic [AW-1:0] incr_next;
  logic [AW-1:0] wrap_step;
  logic [AW-1:0] next_addr;
  logic          last_beat;

  always_comb begin
    cur_beat_bytes = ONE << size_q;
    incr_next      = (addr_q & ~(cur_beat_bytes - ONE)) + cur_beat_bytes;
    wrap_step      = addr_q + cur_beat_bytes;
    last_beat      = (beat_idx_q == len_q);
    unique case (burst_q)
      BURST_INCR: next_addr = incr_next;
      BURST_WRAP: next_addr = (wrap_step == wrap_upper_q) ? wrap_lower_q : wrap_step;
      default:    next_addr = addr_q;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (i_start && !req_illegal) state_d = S_ACTIVE;
        S_ACTIVE: if (i_beat_ack && last_beat) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Outputs, decoded from registered state only.
  always_comb begin
    o_beat_valid = (state_q == S_ACTIVE);
    o_busy       = (state_q == S_ACTIVE);
    o_last       = (state_q == S_ACTIVE) && last_beat;
    o_addr       = addr_q;
    o_beat_idx   = beat_idx_q;
    o_err        = err_q;
  end

  // Datapath: latch on acceptance, step on each acknowledged non-final beat.
  always_comb begin
    addr_d       = addr_q;
    beat_idx_d   = beat_idx_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    wrap_lower_d = wrap_lower_q;
    wrap_upper_d = wrap_upper_q;
    err_d        = 1'b0;

    if (!i_abort) begin
      if (state_q == S_IDLE && i_start) begin
        if (req_illegal) begin
          err_d = 1'b1;
        end else begin
          addr_d       = i_addr;
          beat_idx_d   = '0;
          len_d        = i_len;
          size_d       = i_size;
          burst_d      = burst_e'(i_burst);
          wrap_lower_d = req_wrap_lower;
          wrap_upper_d = req_wrap_upper;
        end
      end else if (state_q == S_ACTIVE && i_beat_ack && !last_beat) begin
        addr_d     = next_addr;
        beat_idx_d = beat_idx_q + LEN_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      addr_q       <= '0;
      beat_idx_q   <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= BURST_FIXED;
      wrap_lower_q <= '0;
      wrap_upper_q <= '0;
      err_q        <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      beat_idx_q   <= beat_idx_d;
      len_q        <= len_d;
      size_q       <= size_d;
      burst_q      <= burst_d;
      wrap_lower_q <= wrap_lower_d;
      wrap_upper_q <= wrap_upper_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench for axi_burst_addr_gen: directed vector table, hand-written
// abort/reset sequences, and randomized bursts against an arithmetic reference model.
module tb_axi_burst_addr_gen;

  localparam int AW       = 64;
  localparam int LW       = 8;
  localparam int MAX_SIZE = 3;

  logic          clk;
  logic          arst;
  logic          i_start;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_len;
  logic [2:0]    i_size;
  logic [1:0]    i_burst;
  logic          i_beat_ack;
  logic          i_abort;
  logic [AW-1:0] o_addr;
  logic          o_beat_valid;
  logic          o_last;
  logic [LW-1:0] o_beat_idx;
  logic          o_busy;
  logic          o_err;

  axi_burst_addr_gen #(
    .AXI_ADDR_WIDTH(AW),
    .LEN_WIDTH     (LW),
    .MAX_SIZE      (MAX_SIZE)
  ) dut (
    .i_clk       (clk),
    .i_arst      (arst),
    .i_start     (i_start),
    .i_addr      (i_addr),
    .i_len       (i_len),
    .i_size      (i_size),
    .i_burst     (i_burst),
    .i_beat_ack  (i_beat_ack),
    .i_abort     (i_abort),
    .o_addr      (o_addr),
    .o_beat_valid(o_beat_valid),
    .o_last      (o_last),
    .o_beat_idx  (o_beat_idx),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] addr;
    int          len;
    int          size;
    int          burst;
    bit          exp_err;
    int          exp_n;
    logic [63:0] a0, a1, a2, a3;
    int          stall_beat;
    int          stall_n;
    bit          rand_stall;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] exp_addrs[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: legality and per-beat addresses from plain arithmetic.
  function automatic bit legal_req(input logic [63:0] addr, input int len, input int size,
                                   input int burst);
    longint unsigned bytes, start, total;
    if (size > MAX_SIZE) return 1'b0;
    if (burst == 3) return 1'b0;
    bytes = longint'(1) << size;
    total = longint'(len + 1) * bytes;
    if (burst == 2) begin
      if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
      if (addr % bytes != 0) return 1'b0;
    end
    if (burst == 1) begin
      start = addr - (addr % bytes);
      if (start / 4096 != (start + total - 1) / 4096) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_addrs(input logic [63:0] addr, input int len, input int size,
                             input int burst);
    longint unsigned bytes, wb, lower;
    bytes = longint'(1) << size;
    wb    = longint'(len + 1) * bytes;
    lower = (addr / wb) * wb;
    exp_addrs.delete();
    for (int i = 0; i <= len; i++) begin
      case (burst)
        0:       exp_addrs.push_back(addr);
        1:       exp_addrs.push_back(i == 0 ? addr : (addr / bytes) * bytes + longint'(i) * bytes);
        default: exp_addrs.push_back(lower + ((addr - lower) + longint'(i) * bytes) % wb);
      endcase
    end
  endtask

  task automatic add_vec(input logic [63:0] addr, input int len, input int size, input int burst,
                         input bit err, input int n, input logic [63:0] a0, input logic [63:0] a1,
                         input logic [63:0] a2, input logic [63:0] a3, input int stall_beat,
                         input int stall_n, input bit rs);
    vec_t v;
    v = '{addr, len, size, burst, err, n, a0, a1, a2, a3, stall_beat, stall_n, rs};
    tbl.push_back(v);
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge where it is idle again.
  task automatic do_burst(input logic [63:0] addr, input int len, input int size, input int burst,
                          input bit exp_err, input int stall_beat, input int stall_n,
                          input bit rand_stall);
    int k;
    int cycles;
    int stalled;
    bit ack;
    i_start = 1'b1;
    i_addr  = addr;
    i_len   = len[LW-1:0];
    i_size  = size[2:0];
    i_burst = burst[1:0];
    @(negedge clk);
    i_start = 1'b0;
    if (exp_err) begin
      check("err_pulse", 64'(o_err), 64'd1);
      check("err_no_valid", 64'(o_beat_valid), 64'd0);
      @(negedge clk);
      check("err_one_cycle", 64'(o_err), 64'd0);
      check("err_stay_idle", 64'(o_beat_valid), 64'd0);
      return;
    end
    check("no_err", 64'(o_err), 64'd0);
    check("first_valid", 64'(o_beat_valid), 64'd1);
    k = 0;
    cycles = 0;
    stalled = 0;
    while (o_beat_valid && cycles < 2000) begin
      if (k < exp_addrs.size()) begin
        check("beat_addr", o_addr, exp_addrs[k]);
        check("beat_idx", 64'(o_beat_idx), 64'(k));
        check("beat_last", 64'(o_last), 64'(k == len));
        check("beat_busy", 64'(o_busy), 64'd1);
      end else begin
        check("beat_overrun", 64'(k), 64'(exp_addrs.size()));
      end
      if (k == stall_beat && stalled < stall_n) begin
        ack = 1'b0;
        stalled++;
      end else if (rand_stall) begin
        ack = 1'($urandom_range(0, 1));
      end else begin
        ack = 1'b1;
      end
      if (ack) k++;
      i_beat_ack = ack;
      @(negedge clk);
      cycles++;
    end
    i_beat_ack = 1'b0;
    check("burst_timeout", 64'(cycles < 2000), 64'd1);
    check("beat_count", 64'(k), 64'(len + 1));
    check("busy_after", 64'(o_busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, o_addr, 64'd0);
    check({tag, "_idx"}, 64'(o_beat_idx), 64'd0);
    check({tag, "_valid"}, 64'(o_beat_valid), 64'd0);
    check({tag, "_last"}, 64'(o_last), 64'd0);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_err"}, 64'(o_err), 64'd0);
  endtask

  initial begin
    arst       = 1'b1;
    i_start    = 1'b0;
    i_addr     = '0;
    i_len      = '0;
    i_size     = '0;
    i_burst    = '0;
    i_beat_ack = 1'b0;
    i_abort    = 1'b0;

    //       addr        len sz bt err n  a0        a1        a2        a3     stall  rnd
    add_vec(64'h1000,    3, 2, 1, 0, 4, 64'h1000, 64'h1004, 64'h1008, 64'h100C, -1, 0, 0);
    add_vec(64'h1003,    2, 2, 1, 0, 3, 64'h1003, 64'h1004, 64'h1008, 64'h0,     0, 2, 0);
    add_vec(64'h2038,    3, 3, 2, 0, 4, 64'h2038, 64'h2020, 64'h2028, 64'h2030, -1, 0, 0);
    add_vec(64'h40,      2, 2, 0, 0, 3, 64'h40,   64'h40,   64'h40,   64'h0,    -1, 0, 1);
    add_vec(64'h40,      0, 2, 0, 0, 1, 64'h40,   64'h0,    64'h0,    64'h0,    -1, 0, 0);
    add_vec(64'h2000,    2, 2, 2, 1, 0, 64'h0,    64'h0,    64'h0,    64'h0,    -1, 0, 0);
    add_vec(64'h2004,    1, 3, 2, 1, 0, 64'h0,    64'h0,    64'h0,    64'h0,    -1, 0, 0);
    add_vec(64'hFF8,     1, 3, 1, 1, 0, 64'h0,    64'h0,    64'h0,    64'h0,    -1, 0, 0);
    add_vec(64'h3000,    1, 2, 3, 1, 0, 64'h0,    64'h0,    64'h0,    64'h0,    -1, 0, 0);
    add_vec(64'h3000,    1, 4, 1, 1, 0, 64'h0,    64'h0,    64'h0,    64'h0,    -1, 0, 0);

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    arst = 1'b0;
    @(negedge clk);

    // Directed vector table.
    foreach (tbl[t]) begin
      logic [63:0] a[4];
      a = '{tbl[t].a0, tbl[t].a1, tbl[t].a2, tbl[t].a3};
      exp_addrs.delete();
      for (int i = 0; i < tbl[t].exp_n; i++) exp_addrs.push_back(a[i]);
      do_burst(tbl[t].addr, tbl[t].len, tbl[t].size, tbl[t].burst, tbl[t].exp_err,
               tbl[t].stall_beat, tbl[t].stall_n, tbl[t].rand_stall);
    end

    // Longest burst: beat index climbs to 255 without wrapping.
    model_addrs(64'h7000, 255, 0, 1);
    do_burst(64'h7000, 255, 0, 1, 1'b0, -1, 0, 1'b0);

    // Abort after the first ack, then an immediate restart.
    i_start = 1'b1; i_addr = 64'h3000; i_len = 8'd7; i_size = 3'd2; i_burst = 2'b01;
    @(negedge clk);
    i_start = 1'b0;
    check("abort_first_addr", o_addr, 64'h3000);
    i_beat_ack = 1'b1;
    @(negedge clk);
    check("abort_second_addr", o_addr, 64'h3004);
    i_beat_ack = 1'b0;
    i_abort    = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_valid", 64'(o_beat_valid), 64'd0);
    check("abort_busy", 64'(o_busy), 64'd0);
    model_addrs(64'h3100, 1, 2, 1);
    do_burst(64'h3100, 1, 2, 1, 1'b0, -1, 0, 1'b0);

    // Start and abort together: request dropped, no error even for an illegal one.
    for (int c = 0; c < 2; c++) begin
      i_start = 1'b1; i_abort = 1'b1;
      i_addr = 64'h4000; i_len = 8'd1; i_size = 3'd2; i_burst = (c == 0) ? 2'b01 : 2'b11;
      @(negedge clk);
      i_start = 1'b0; i_abort = 1'b0;
      check("start_abort_valid", 64'(o_beat_valid), 64'd0);
      check("start_abort_err", 64'(o_err), 64'd0);
      @(negedge clk);
      check("start_abort_err2", 64'(o_err), 64'd0);
    end

    // Asynchronous reset in the middle of a burst.
    i_start = 1'b1; i_addr = 64'h5000; i_len = 8'd7; i_size = 3'd3; i_burst = 2'b01;
    @(negedge clk);
    i_start    = 1'b0;
    i_beat_ack = 1'b1;
    repeat (2) @(negedge clk);
    i_beat_ack = 1'b0;
    check("pre_reset_valid", 64'(o_beat_valid), 64'd1);
    #2 arst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check("post_reset_valid", 64'(o_beat_valid), 64'd0);

    // Randomized bursts against the reference model.
    for (int r = 0; r < 60; r++) begin
      logic [63:0] addr;
      int sel, burst, size, len;
      bit legal;
      sel   = $urandom_range(0, 9);
      burst = (sel < 2) ? 0 : (sel < 6) ? 1 : (sel < 9) ? 2 : 3;
      size  = ($urandom_range(0, 9) == 0) ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3);
      if (burst == 2) begin
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15)
                                           : (2 << $urandom_range(0, 3)) - 1;
      end else begin
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      end
      addr = (64'($urandom_range(0, 20'hFFFFF)) << 12) | 64'($urandom_range(0, 4095));
      if (burst == 2 && $urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
      legal = legal_req(addr, len, size, burst);
      if (legal) model_addrs(addr, len, size, burst);
      do_burst(addr, len, size, burst, !legal, -1, 0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_burst_addr_gen.md
Name: axi_burst_addr_gen

Overview:
Per-beat address generator for full AXI4 bursts; successor to the fixed +4 AXI4-Lite burst incrementer. Supports FIXED, INCR and WRAP burst types, beats of 1 to 2^MAX_SIZE bytes, and lengths up to 2^LEN_WIDTH beats. It validates each request (including 4 KB boundary crossing), then presents one address per beat under a valid/ack handshake. It sits between the cache/DMA request logic and the AXI4 master channel FSM.

Parameters:
AXI_ADDR_WIDTH, 64, address width; all address arithmetic is modulo 2^AXI_ADDR_WIDTH.
LEN_WIDTH, 8, width of the beat-count field (AXI AxLEN); a burst has len+1 beats.
MAX_SIZE, 3, largest legal log2(bytes per beat); 3 means 8-byte beats.

Ports:
i_clk  input  1  clock; all state changes on its rising edge.
i_arst  input  1  asynchronous reset, active-high.
i_start  input  1  request strobe; sampled only in IDLE.
i_addr  input  AXI_ADDR_WIDTH  burst start address.
i_len  input  LEN_WIDTH  beats minus one.
i_size  input  3  log2 bytes per beat.
i_burst  input  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
i_beat_ack  input  1  consumer accepts the current beat.
i_abort  input  1  abandons the burst, like a bus-free clear.
o_addr  output  AXI_ADDR_WIDTH  current beat address (registered).
o_beat_valid  output  1  o_addr holds a valid beat.
o_last  output  1  current beat is the final beat; only meaningful while o_beat_valid.
o_beat_idx  output  LEN_WIDTH  zero-based index of the current beat.
o_busy  output  1  high in ACTIVE.
o_err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - o_addr, o_beat_idx, o_beat_valid, o_last, o_busy and o_err are all 0.
  - Latched request fields are cleared.
- States: IDLE and ACTIVE.
- Priority, every cycle: i_arst, then i_abort, then everything else.
- i_abort in any state:
  - Next state is IDLE; o_beat_valid and o_busy are 0 from the next cycle.
  - If i_start and i_abort are both high in IDLE, the request is dropped and o_err is not raised.
- IDLE with i_start=1: the request is checked. It is illegal if any of the following holds:
  - i_size > MAX_SIZE;
  - i_burst = 11;
  - WRAP with i_len not in {1, 3, 7, 15};
  - WRAP with i_addr not aligned to 2^i_size;
  - INCR where the aligned start address and the last byte, aligned_start + ((i_len+1) << i_size) - 1, differ in address bits [AXI_ADDR_WIDTH-1:12] (the burst crosses a 4 KB boundary).
- Illegal request: o_err=1 for exactly the next cycle; the FSM stays in IDLE.
- Legal request:
  - Fields are latched and the FSM enters ACTIVE next cycle.
  - That cycle shows o_addr=i_addr unmodified (unaligned start is allowed for FIXED and INCR), o_beat_idx=0, o_beat_valid=1.
- ACTIVE:
  - o_beat_valid stays 1 and o_addr and o_beat_idx are held until i_beat_ack=1.
  - o_last = (o_beat_idx == len), combinational from registered state.
  - i_start is ignored in ACTIVE.
- On ack of a beat that is not the last, o_beat_idx increments and o_addr updates next cycle:
  - FIXED: o_addr is unchanged.
  - INCR: next = (o_addr with its low i_size bits cleared) + 2^size. Only the first beat can be unaligned; later beats are aligned.
  - WRAP: wrap_bytes = (len+1) << size; lower = start & ~(wrap_bytes-1); next = o_addr + 2^size; if next == lower + wrap_bytes, then next = lower.
- On ack of the last beat: next cycle is IDLE, with o_beat_valid=0 and o_busy=0. A new i_start is accepted in that IDLE cycle, so the minimum gap between bursts is one cycle.
- Single-beat burst (len=0): o_last is 1 on the first beat.
- len = 2^LEN_WIDTH-1: o_beat_idx reaches its maximum without wrapping, then the FSM returns to IDLE.
- Reset asserted mid-burst: all outputs go to reset values immediately (asynchronously); the burst is lost.

Test Plan:
1. INCR, addr=0x1000, len=3, size=2, ack every cycle -> o_addr 0x1000, 0x1004, 0x1008, 0x100C; o_last only on the 4th beat; o_busy=0 the following cycle.
2. Unaligned INCR, addr=0x1003, size=2, len=2, ack held low 2 cycles on beat 1 -> o_addr 0x1003 (held for the stall), 0x1004, 0x1008; o_beat_idx 0, 1, 2.
3. WRAP, addr=0x2038, size=3, len=3 -> o_addr 0x2038, 0x2020, 0x2028, 0x2030; o_last on 0x2030.
4. FIXED, addr=0x40, len=2, random ack stalls -> exactly 3 beats, all at 0x40; len=0 burst -> single beat with o_last=1.
5. Illegal requests -> o_err one-cycle pulse, o_beat_valid stays 0, for each of:
   - WRAP len=2;
   - WRAP addr=0x2004, size=3;
   - INCR addr=0xFF8, size=3, len=1 (crosses 4 KB);
   - burst=11;
   - size=4 with MAX_SIZE=3.
6. Abort and reset:
   - i_abort after the first ack of an INCR len=7 burst -> o_beat_valid=0 next cycle; a new start in the following cycle is accepted.
   - i_abort and i_start together in IDLE -> no burst, no o_err.
   - i_arst pulse mid-burst -> all outputs 0 immediately.
